// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, one bit per cycle).
// Latency: XLEN+1 cycles after accept; 1 cycle for divide-by-zero / signed overflow (special cases).
// Backpressure: busy stays high while in flight; start is only sampled in IDLE; flush aborts. Divider gated by MULDIV_DIV_EN.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_f3;
    logic                r_neg;
    logic                r_special;
    logic [2*XLEN-1:0]   r_acc;     // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
    logic [XLEN-1:0]     r_b;       // mul: multiplicand magnitude; div: divisor magnitude
    logic [XLEN-1:0]     r_result;
    logic                r_done;
    logic                r_busy;

    // Operand signedness and magnitudes, decoded from funct3 at accept time
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_neg;
    logic                w_special;
    logic [XLEN-1:0]     w_pre;

    assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_sa       = w_a_signed & op_a[XLEN-1];
    assign w_sb       = w_b_signed & op_b[XLEN-1];
    assign w_mag_a    = w_sa ? -op_a : op_a;
    assign w_mag_b    = w_sb ? -op_b : op_b;
    // REM takes the dividend's sign; everything else takes sign(a) ^ sign(b)
    assign w_neg      = (funct3[2] & funct3[1]) ? w_sa : (w_sa ^ w_sb);

`ifdef MULDIV_DIV_EN
    logic                w_div_zero;
    logic                w_ovf;
    assign w_div_zero = (op_b == '0);
    assign w_ovf      = ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign w_special  = funct3[2] & (w_div_zero | w_ovf);
    // Divide-by-zero: quotient all-ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
    assign w_pre      = w_div_zero ? (funct3[1] ? op_a : '1)
                                   : (funct3[1] ? '0   : op_a);
`else
    // Without the divider every divide request completes immediately with zero
    assign w_special  = funct3[2];
    assign w_pre      = '0;
`endif

    // One multiply step: add multiplicand into the high half when the low bit is set, then shift right
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_mul_nxt;
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

    logic [2*XLEN-1:0]   w_div_nxt;
`ifdef MULDIV_DIV_EN
    // One restoring-divide step: shift {rem, quot} left, keep the trial subtraction if it did not borrow
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};
`else
    assign w_div_nxt = r_acc;
`endif

    logic [2*XLEN-1:0]   w_step;
    assign w_step = r_f3[2] ? w_div_nxt : w_mul_nxt;

    // Sign fix-up and result selection applied in the FIX state
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_q;
    logic [XLEN-1:0]     w_r;
    logic [XLEN-1:0]     w_fix;
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_q    = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_r    = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Select the final value: preloaded special result, quotient/remainder, or product half
    always_comb begin
        w_fix = '0;
        if (r_special) begin
            w_fix = r_acc[XLEN-1:0];
        end else if (r_f3[2]) begin
            w_fix = r_f3[1] ? w_r : w_q;
        end else if (r_f3[1:0] == 2'b00) begin
            w_fix = w_prod[XLEN-1:0];
        end else begin
            w_fix = w_prod[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath registers: accept, iterate, fix up, or abort on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_acc     <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_f3   <= funct3;
                        r_neg  <= w_neg;
                        r_busy <= 1'b1;
                        if (w_special) begin
                            r_special <= 1'b1;
                            r_acc     <= {{XLEN{1'b0}}, w_pre};
                            r_cnt     <= '0;
                            r_state   <= S_FIX;
                        end else begin
                            r_special <= 1'b0;
                            r_acc     <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                            r_b       <= funct3[2] ? w_mag_b : w_mag_a;
                            r_cnt     <= CW'(XLEN);
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    if (!flush) begin
                        r_result <= w_fix;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative RV32M multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle ALU in EX: the control unit steers M-extension R-format instructions (opcode 0110011, funct7 = 0000001) here and stalls the pipeline while `busy` is high.
- Decodes the operation from funct3 and computes one bit per cycle.
- Handles signedness, divide-by-zero and signed overflow per the RISC-V spec.

## Interface

Parameters:
- `XLEN`, 32: operand/result width; must be ≥ 4.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  inst[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value (multiplicand/dividend).
- `op_b`  in  XLEN  rs2 value (multiplier/divisor).
- `flush`  in  1  abort current operation.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse, `result` valid.
- `result`  out  XLEN  registered result; held until next `done`.

## Operation

- **FSM states:** IDLE, CALC, FIX.
- **Accept:** a rising edge with state = IDLE, `start` = 1, `flush` = 0 latches `funct3`, operand magnitudes and the result sign.
  - Inputs are ignored in every other state.
- **Signedness:**
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats `op_a` as signed and `op_b` as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
- **Result sign:**
  - Multiply: sign(a) XOR sign(b), using only the operands treated as signed.
  - DIV: sign(a) XOR sign(b).
  - REM: sign(a).
- **Multiply:**
  - Shift-add on magnitudes into a 2·XLEN product, one multiplier bit per CALC cycle.
  - FIX conditionally negates the full 2·XLEN product.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- **Divide:**
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - FIX conditionally negates the quotient or remainder.
- **Special cases** (detected at accept; go straight to FIX with the result preloaded):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return `op_a`.
  - Signed overflow (DIV/REM with `op_a` = 1 followed by XLEN-1 zeros and `op_b` = all-ones): DIV returns `op_a`; REM returns 0.
- **Transitions:**
  - IDLE → CALC on accept, with the counter loaded to XLEN.
  - IDLE → FIX on accept of a special case.
  - CALC → FIX when the counter reaches 1.
  - FIX → IDLE always, registering `result` and asserting `done`.
- **Flush:**
  - In CALC or FIX, the next edge returns to IDLE.
  - No `done`; `result` keeps its previous value.
  - `flush` in IDLE blocks acceptance even when `start` = 1.
- **Reset** (mid-operation or otherwise) forces IDLE immediately: `busy` = 0, `done` = 0, `result` = 0, counter = 0.

## Timing

- Accept edge = E0.
- `busy` rises after E0 and falls after the edge that asserts `done`.
- Normal operation:
  - CALC occupies E1..E(XLEN).
  - FIX edge E(XLEN+1) asserts `done`.
  - Latency is XLEN+1 cycles after accept (33 for XLEN = 32).
- Special case: FIX at E1 asserts `done`; latency 1 cycle.
- `done` is high for exactly one cycle, with state = IDLE. A new `start` in that same cycle is accepted (back-to-back issue).
- `result` changes only on the edge that asserts `done`.

## Configuration

- `MULDIV_DIV_EN` defined: full divider included as above.
- `MULDIV_DIV_EN` undefined: divider datapath removed.
  - funct3[2] = 1 requests take the special-case path and return `result` = 0, with `done` 1 cycle after accept.
  - Multiply behaviour and timing are unchanged.

## Test plan

- MUL, `op_a` = 7, `op_b` = 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB; `done` 33 cycles after accept; `busy` high for exactly 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with `done` 1 cycle after accept. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Flush 10 cycles into a MUL → `busy` low next cycle, no `done`, `result` unchanged. A MUL issued next cycle completes normally. `start` with `flush` in IDLE is not accepted.
- Assert `rst_n` = 0 mid-DIV → outputs 0 immediately. Back-to-back MUL issued on the `done` cycle → second `done` 33 cycles later. Without `MULDIV_DIV_EN`: DIV 9/3 → 0 after 1 cycle.
